// File: rtl/dr_file_if.sv
// Controller-side bundle for the data-register file: write/operate port,
// two read ports and the flag/valid status returned to the controller.
interface dr_file_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] dout_a;
    logic [WIDTH-1:0] dout_b;
    logic             zf;
    logic             cf;
    logic [DEPTH-1:0] vld;

    modport master (
        output we, waddr, op, din, raddr_a, raddr_b,
        input  dout_a, dout_b, zf, cf, vld
    );

    modport slave (
        input  we, waddr, op, din, raddr_a, raddr_b,
        output dout_a, dout_b, zf, cf, vld
    );
endinterface

// File: rtl/dr_file.sv
// DEPTH x WIDTH register file with one in-place operate/write port,
// two combinational read ports and registered zero/carry/valid status.
module dr_file #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    dr_file_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_CLR  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROTL = 3'b110,
        OP_ROTR = 3'b111
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic             res_cf;

    // Result and carry-out of the selected operation on the addressed entry
    always_comb begin
        cur    = mem_q[bus.waddr];
        res    = cur;
        res_cf = 1'b0;
        unique case (op_e'(bus.op))
            OP_LOAD: res = bus.din;
            OP_CLR:  res = '0;
            OP_INC: begin
                res    = cur + WIDTH'(1);
                res_cf = &cur;
            end
            OP_DEC: begin
                res    = cur - WIDTH'(1);
                res_cf = ~|cur;
            end
            OP_SHL: begin
                res    = {cur[WIDTH-2:0], 1'b0};
                res_cf = cur[WIDTH-1];
            end
            OP_SHR: begin
                res    = {1'b0, cur[WIDTH-1:1]};
                res_cf = cur[0];
            end
            OP_ROTL: begin
                res    = {cur[WIDTH-2:0], cur[WIDTH-1]};
                res_cf = cur[WIDTH-1];
            end
            OP_ROTR: begin
                res    = {cur[0], cur[WIDTH-1:1]};
                res_cf = cur[0];
            end
            default: begin
                res    = cur;
                res_cf = 1'b0;
            end
        endcase
    end

    // Next state: only the addressed entry and the status flags move on we
    always_comb begin
        mem_d = mem_q;
        zf_d  = zf_q;
        cf_d  = cf_q;
        vld_d = vld_q;
        if (bus.we) begin
            mem_d[bus.waddr] = res;
            zf_d             = ~|res;
            cf_d             = res_cf;
            vld_d[bus.waddr] = (op_e'(bus.op) != OP_CLR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            zf_q  <= 1'b0;
            cf_q  <= 1'b0;
            vld_q <= '0;
        end else begin
            mem_q <= mem_d;
            zf_q  <= zf_d;
            cf_q  <= cf_d;
            vld_q <= vld_d;
        end
    end

    // Reads see stored state only; a same-cycle write is not bypassed
    assign bus.dout_a = mem_q[bus.raddr_a];
    assign bus.dout_b = mem_q[bus.raddr_b];
    assign bus.zf     = zf_q;
    assign bus.cf     = cf_q;
    assign bus.vld    = vld_q;

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;
endmodule

// File: tb/tb_dr_file.sv
// Directed bench for dr_file: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the rising edge.
module tb_dr_file;
    localparam logic [2:0] LOAD = 3'b000, CLR = 3'b001, INC = 3'b010, DEC = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ROTL = 3'b110, ROTR = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    dr_file_if #(.WIDTH(8), .DEPTH(4)) bus ();

    dr_file #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [1:0] a, input logic [2:0] o, input logic [7:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.op    = o;
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic test_reset();
        bus.we = 1'b0; bus.waddr = '0; bus.op = LOAD; bus.din = '0;
        bus.raddr_a = 2'd2; bus.raddr_b = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_dout_a: got %h want 00", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.zf, bus.cf}); end
        n_checks++; if (bus.vld !== 4'b0000) begin n_fail++; $display("FAIL reset_vld: got %b want 0000", bus.vld); end
        rst = 1'b1;
    endtask

    task automatic test_load();
        do_op(2'd2, LOAD, 8'hA5);
        n_checks++; if (bus.dout_a !== 8'hA5) begin n_fail++; $display("FAIL load_dout_a: got %h want a5", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b00) begin n_fail++; $display("FAIL load_flags: got %b want 00", {bus.zf, bus.cf}); end
        n_checks++; if (bus.vld !== 4'b0100) begin n_fail++; $display("FAIL load_vld: got %b want 0100", bus.vld); end
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                bus.raddr_b = 2'(i);
                #1;
                n_checks++; if (bus.dout_b !== 8'h00) begin n_fail++; $display("FAIL load_other_%0d: got %h want 00", i, bus.dout_b); end
            end
        end
    endtask

    task automatic test_inc_dec();
        bus.raddr_a = 2'd1;
        do_op(2'd1, LOAD, 8'hFF);
        n_checks++; if (bus.vld !== 4'b0110) begin n_fail++; $display("FAIL incdec_vld: got %b want 0110", bus.vld); end
        bus.we = 1'b1; bus.op = INC;
        @(posedge clk); #1;
        n_checks++; if (bus.dout_a !== 8'h00) begin n_fail++; $display("FAIL inc_wrap: got %h want 00", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b11) begin n_fail++; $display("FAIL inc_flags: got %b want 11", {bus.zf, bus.cf}); end
        do_op(2'd1, DEC, 8'h00);
        n_checks++; if (bus.dout_a !== 8'hFF) begin n_fail++; $display("FAIL dec_wrap: got %h want ff", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b01) begin n_fail++; $display("FAIL dec_flags: got %b want 01", {bus.zf, bus.cf}); end
    endtask

    task automatic test_back_to_back();
        bus.raddr_a = 2'd3;
        bus.we = 1'b1; bus.waddr = 2'd3; bus.op = LOAD; bus.din = 8'h0F;
        @(posedge clk); #1;
        bus.op = INC;
        @(posedge clk); #1;
        n_checks++; if (bus.dout_a !== 8'h10) begin n_fail++; $display("FAIL b2b_inc1: got %h want 10", bus.dout_a); end
        @(posedge clk); #1;
        bus.we = 1'b0;
        n_checks++; if (bus.dout_a !== 8'h11) begin n_fail++; $display("FAIL b2b_inc2: got %h want 11", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags: got %b want 00", {bus.zf, bus.cf}); end
    endtask

    task automatic test_shift_rotate();
        logic [2:0] ops  [6] = '{SHL, SHR, ROTR, ROTL, ROTR, SHL};
        logic [7:0] expq [6] = '{8'h02, 8'h01, 8'h80, 8'h01, 8'h80, 8'h00};
        logic [1:0] expf [6] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        bus.raddr_a = 2'd0;
        do_op(2'd0, LOAD, 8'h81);
        n_checks++; if (bus.dout_a !== 8'h81) begin n_fail++; $display("FAIL shift_load: got %h want 81", bus.dout_a); end
        for (int i = 0; i < 6; i++) begin
            do_op(2'd0, ops[i], 8'h00);
            n_checks++; if (bus.dout_a !== expq[i]) begin n_fail++; $display("FAIL shift_q_%0d: got %h want %h", i, bus.dout_a, expq[i]); end
            n_checks++; if ({bus.zf, bus.cf} !== expf[i]) begin n_fail++; $display("FAIL shift_flags_%0d: got %b want %b", i, {bus.zf, bus.cf}, expf[i]); end
        end
    endtask

    task automatic test_same_cycle();
        bus.raddr_a = 2'd3; bus.raddr_b = 2'd3;
        bus.we = 1'b1; bus.waddr = 2'd3; bus.op = LOAD; bus.din = 8'h3C;
        #1;
        n_checks++; if ({bus.dout_a, bus.dout_b} !== 16'h1111) begin n_fail++; $display("FAIL same_pre: got %h want 1111", {bus.dout_a, bus.dout_b}); end
        @(posedge clk); #1;
        n_checks++; if ({bus.dout_a, bus.dout_b} !== 16'h3C3C) begin n_fail++; $display("FAIL same_post: got %h want 3c3c", {bus.dout_a, bus.dout_b}); end
        bus.we = 1'b0; bus.op = INC;
        @(posedge clk); #1;
        n_checks++; if (bus.dout_a !== 8'h3C) begin n_fail++; $display("FAIL idle_hold: got %h want 3c", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b00) begin n_fail++; $display("FAIL idle_flags: got %b want 00", {bus.zf, bus.cf}); end
        n_checks++; if (bus.vld !== 4'b1111) begin n_fail++; $display("FAIL idle_vld: got %b want 1111", bus.vld); end
    endtask

    task automatic test_clear();
        bus.raddr_a = 2'd2; bus.raddr_b = 2'd1;
        do_op(2'd2, LOAD, 8'h55);
        do_op(2'd1, INC, 8'h00);
        n_checks++; if ({bus.dout_b, bus.zf, bus.cf} !== 10'b00000000_11) begin n_fail++; $display("FAIL pre_clear: got %h/%b want 00/11", bus.dout_b, {bus.zf, bus.cf}); end
        do_op(2'd2, CLR, 8'hAA);
        n_checks++; if (bus.dout_a !== 8'h00) begin n_fail++; $display("FAIL clear_q: got %h want 00", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b10) begin n_fail++; $display("FAIL clear_flags: got %b want 10", {bus.zf, bus.cf}); end
        n_checks++; if (bus.vld !== 4'b1011) begin n_fail++; $display("FAIL clear_vld: got %b want 1011", bus.vld); end
    endtask

    task automatic test_async_reset();
        bus.raddr_a = 2'd0; bus.raddr_b = 2'd3;
        do_op(2'd0, LOAD, 8'hFE);
        bus.we = 1'b1; bus.waddr = 2'd0; bus.op = INC;
        @(posedge clk); #1;
        n_checks++; if (bus.dout_a !== 8'hFF) begin n_fail++; $display("FAIL ar_inc1: got %h want ff", bus.dout_a); end
        @(posedge clk); #1;
        n_checks++; if ({bus.dout_a, bus.zf, bus.cf} !== 10'b00000000_11) begin n_fail++; $display("FAIL ar_inc2: got %h/%b want 00/11", bus.dout_a, {bus.zf, bus.cf}); end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.dout_a, bus.dout_b} !== 16'h0000) begin n_fail++; $display("FAIL ar_dout: got %h want 0000", {bus.dout_a, bus.dout_b}); end
        n_checks++; if ({bus.zf, bus.cf, bus.vld} !== 6'b0) begin n_fail++; $display("FAIL ar_status: got %b want 000000", {bus.zf, bus.cf, bus.vld}); end
        @(posedge clk); #1;
        n_checks++; if (bus.dout_a !== 8'h00) begin n_fail++; $display("FAIL ar_held: got %h want 00", bus.dout_a); end
        bus.we = 1'b0;
        rst = 1'b1;
        do_op(2'd0, INC, 8'h00);
        n_checks++; if (bus.dout_a !== 8'h01) begin n_fail++; $display("FAIL post_rst_inc: got %h want 01", bus.dout_a); end
        n_checks++; if ({bus.zf, bus.cf} !== 2'b00) begin n_fail++; $display("FAIL post_rst_flags: got %b want 00", {bus.zf, bus.cf}); end
        n_checks++; if (bus.vld !== 4'b0001) begin n_fail++; $display("FAIL post_rst_vld: got %b want 0001", bus.vld); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_inc_dec();
        test_back_to_back();
        test_shift_rotate();
        test_same_cycle();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
